// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer owning HI/LO with hazard stall generation
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  input  logic        hilo_sel,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0] a_q, b_q;
  logic [2:0] op_q;
  logic start, done, wr;
  logic [31:0] bd, ma, mb, uq, ur, mq, mr, sq, sr;
  logic signed [63:0] ps;
  logic [63:0] res;
  assign start    = md_op_E inside {3'd1, 3'd2, 3'd3, 3'd4};
  assign done     = state == RUN && cnt == CW'(1);
  assign wr       = done && !(op_q >= 3'd3 && b_q == 32'd0);
  assign busy     = state == RUN;
  assign stall_md = md_use_D & (busy | start);
  assign hilo_rd  = hilo_sel ? hi : lo;
  // Divide through magnitudes so the most-negative / -1 case wraps cleanly; zero divisor is masked, result unused
  always_comb begin
    bd  = b_q == 32'd0 ? 32'd1 : b_q;
    ma  = a_q[31] ? -a_q : a_q;
    mb  = bd[31] ? -bd : bd;
    uq  = a_q / bd;
    ur  = a_q % bd;
    mq  = ma / mb;
    mr  = ma % mb;
    sq  = (a_q[31] ^ b_q[31]) ? -mq : mq;
    sr  = a_q[31] ? -mr : mr;
    ps  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    res = op_q == 3'd1 ? ps :
          op_q == 3'd2 ? {32'd0, a_q} * {32'd0, b_q} :
          op_q == 3'd3 ? {sr, sq} : {ur, uq};
  end
  // Next state: start leaves IDLE, last countdown cycle returns
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : (done ? IDLE : RUN);
  end
  // State register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
  end
  // Operand latch, countdown and HI/LO writeback; ops arriving during RUN are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        a_q  <= rs_E;
        b_q  <= rt_E;
        op_q <= md_op_E;
        cnt  <= md_op_E <= 3'd2 ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end
      if (md_op_E == 3'd5) hi <= rs_E;
      if (md_op_E == 3'd6) lo <= rs_E;
    end else begin
      cnt <= cnt - CW'(1);
      if (wr) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
    end
  end
endmodule
